// File: rtl/game_pkg.sv
// Shared state encoding and default frame budgets for the game sequencer
// and every block that decodes its state.
package game_pkg;

  typedef enum logic [2:0] {
    ST_MENU     = 3'd0,
    ST_INTRO    = 3'd1,
    ST_PLAY     = 3'd2,
    ST_DEATH    = 3'd3,
    ST_WIN      = 3'd4,
    ST_GAMEOVER = 3'd5
  } game_state_t;

  localparam int unsigned CNT_W            = 8;
  localparam int unsigned LIVES_W          = 2;
  localparam int unsigned INTRO_FRAMES_DEF = 180;
  localparam int unsigned DEATH_FRAMES_DEF = 120;
  localparam int unsigned WIN_FRAMES_DEF   = 180;
  localparam int unsigned OVER_FRAMES_DEF  = 240;
  localparam int unsigned LIVES_DEF        = 3;

endpackage

// File: rtl/frame_timer.sv
// Frame tick from the vsync rising edge plus a clearable, saturating
// count of frames completed since the last clear.
module frame_timer
  import game_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             vsync,
  input  logic             clr,
  output logic             tick_c,
  output logic [CNT_W-1:0] count
);

  logic             vsync_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb tick_c = vsync & ~vsync_q;

  // Clear has priority so a new state always starts from zero frames.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (tick_c && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q <= 1'b0;
      count_q <= '0;
    end else begin
      vsync_q <= vsync;
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/game_controller.sv
// Game sequencer: MENU -> INTRO -> PLAY -> DEATH/WIN/GAMEOVER -> MENU,
// paced by VGA frames, driving the shared start/animation/freeze controls.
module game_controller
  import game_pkg::*;
#(
  parameter int unsigned INTRO_FRAMES = INTRO_FRAMES_DEF,
  parameter int unsigned DEATH_FRAMES = DEATH_FRAMES_DEF,
  parameter int unsigned WIN_FRAMES   = WIN_FRAMES_DEF,
  parameter int unsigned OVER_FRAMES  = OVER_FRAMES_DEF,
  parameter int unsigned LIVES        = LIVES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vsync,
  input  logic       start_key,
  input  logic       anim_done,
  input  logic       hit,
  input  logic       goal,
  output logic       start_game,
  output logic       animation,
  output logic       freeze,
  output logic       respawn,
  output logic       level_clear,
  output logic [1:0] lives,
  output logic [2:0] state
);

  localparam logic [CNT_W-1:0]   INTRO_LAST = CNT_W'(INTRO_FRAMES - 1);
  localparam logic [CNT_W-1:0]   DEATH_LAST = CNT_W'(DEATH_FRAMES - 1);
  localparam logic [CNT_W-1:0]   WIN_LAST   = CNT_W'(WIN_FRAMES - 1);
  localparam logic [CNT_W-1:0]   OVER_LAST  = CNT_W'(OVER_FRAMES - 1);
  localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(LIVES);

  game_state_t        state_q, state_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic               start_key_q;
  logic               start_game_q, start_game_d;
  logic               animation_q, animation_d;
  logic               freeze_q, freeze_d;
  logic               respawn_q, respawn_d;
  logic               level_clear_q, level_clear_d;

  logic               start_edge_c;
  logic               state_chg_c;
  logic               tick_c;
  logic [CNT_W-1:0]   frame_cnt;

  frame_timer u_frame_timer (
    .clk    (clk),
    .rst_n  (rst),
    .vsync  (vsync),
    .clr    (state_chg_c),
    .tick_c (tick_c),
    .count  (frame_cnt)
  );

  always_comb start_edge_c = start_key & ~start_key_q;
  always_comb state_chg_c  = (state_d != state_q);

  // Next state, lives and pulse generation; outputs decode the next state.
  always_comb begin
    state_d       = state_q;
    lives_d       = lives_q;
    respawn_d     = 1'b0;
    level_clear_d = 1'b0;
    case (state_q)
      ST_MENU: begin
        if (start_edge_c) begin
          state_d = ST_INTRO;
          lives_d = LIVES_INIT;
        end
      end
      ST_INTRO: begin
        if (anim_done || (tick_c && (frame_cnt == INTRO_LAST))) begin
          state_d   = ST_PLAY;
          respawn_d = 1'b1;
        end
      end
      ST_PLAY: begin
        if (hit) begin
          state_d = ST_DEATH;
          if (lives_q != '0) lives_d = lives_q - LIVES_W'(1);
        end else if (goal) begin
          state_d       = ST_WIN;
          level_clear_d = 1'b1;
        end
      end
      ST_DEATH: begin
        if (tick_c && (frame_cnt == DEATH_LAST)) begin
          if (lives_q == '0) begin
            state_d = ST_GAMEOVER;
          end else begin
            state_d   = ST_PLAY;
            respawn_d = 1'b1;
          end
        end
      end
      ST_WIN: begin
        if (tick_c && (frame_cnt == WIN_LAST)) state_d = ST_MENU;
      end
      ST_GAMEOVER: begin
        if ((tick_c && (frame_cnt == OVER_LAST)) || start_edge_c) state_d = ST_MENU;
      end
      default: state_d = ST_MENU;
    endcase

    start_game_d = (state_d != ST_MENU);
    animation_d  = (state_d == ST_INTRO);
    freeze_d     = (state_d != ST_PLAY);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_MENU;
      lives_q       <= '0;
      start_key_q   <= 1'b0;
      start_game_q  <= 1'b0;
      animation_q   <= 1'b0;
      freeze_q      <= 1'b1;
      respawn_q     <= 1'b0;
      level_clear_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      lives_q       <= lives_d;
      start_key_q   <= start_key;
      start_game_q  <= start_game_d;
      animation_q   <= animation_d;
      freeze_q      <= freeze_d;
      respawn_q     <= respawn_d;
      level_clear_q <= level_clear_d;
    end
  end

  assign state       = state_q;
  assign lives       = lives_q;
  assign start_game  = start_game_q;
  assign animation   = animation_q;
  assign freeze      = freeze_q;
  assign respawn     = respawn_q;
  assign level_clear = level_clear_q;

endmodule
